// File: rtl/wptr_full_if.sv
// Write-side bundle between the FIFO producer and the write-pointer/full-flag block.
// The master modport is the producer; the slave modport is wptr_full.
interface wptr_full_if #(
  parameter int ADDR_WIDTH = 4
) ();
  logic                  winc;
  logic [ADDR_WIDTH:0]   wq2_rptr;
  logic                  wovf_clr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  wen;
  logic                  wfull;
  logic [ADDR_WIDTH:0]   wcount;
  logic                  walmost_full;
  logic                  woverflow;

  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  waddr, wptr, wen, wfull, wcount, walmost_full, woverflow
  );

  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output waddr, wptr, wen, wfull, wcount, walmost_full, woverflow
  );
endinterface

// File: rtl/wptr_full.sv
// Async-FIFO write pointer, Gray pointer and conservative full/overflow flags.
// Define WPTR_FULL_ALMOST_FULL_EN to build the occupancy counter and almost-full flag.
module wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic         wclk,
  input  logic         wrst,
  wptr_full_if.slave   wif
);
  localparam int A     = ADDR_WIDTH;
  localparam int DEPTH = 1 << A;

  logic [A:0] wbin_q,  wbin_d;
  logic [A:0] wptr_q,  wptr_d;
  logic       wfull_q, wfull_d;
  logic       woverflow_q, woverflow_d;
  logic       accept;
  logic [A:0] rptr_full_cmp;

  // Full when the write pointer has lapped the read pointer: top two Gray bits differ, rest equal.
  assign rptr_full_cmp = {~wif.wq2_rptr[A:A-1], wif.wq2_rptr[A-2:0]};

  always_comb begin
    accept      = wif.winc & ~wfull_q;
    wbin_d      = wbin_q + {{A{1'b0}}, accept};
    wptr_d      = wbin_d ^ (wbin_d >> 1);
    wfull_d     = (wptr_d == rptr_full_cmp);
    woverflow_d = woverflow_q;
    if (wif.winc && wfull_q)  woverflow_d = 1'b1;
    else if (wif.wovf_clr)    woverflow_d = 1'b0;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q      <= '0;
      wptr_q      <= '0;
      wfull_q     <= 1'b0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wptr_q      <= wptr_d;
      wfull_q     <= wfull_d;
      woverflow_q <= woverflow_d;
    end
  end

  assign wif.waddr     = wbin_q[A-1:0];
  assign wif.wptr      = wptr_q;
  assign wif.wen       = accept;
  assign wif.wfull     = wfull_q;
  assign wif.woverflow = woverflow_q;

`ifdef WPTR_FULL_ALMOST_FULL_EN
  localparam logic [A:0] AF_TH = (A+1)'(DEPTH - AF_MARGIN);

  function automatic logic [A:0] gray2bin(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [A:0] rbin_s;
  logic [A:0] occ;
  logic [A:0] wcount_q, wcount_d;
  logic       walmost_full_q, walmost_full_d;

  // Occupancy against the stale read pointer, so it can only over-report.
  always_comb begin
    rbin_s         = gray2bin(wif.wq2_rptr);
    occ            = wbin_d - rbin_s;
    wcount_d       = occ;
    walmost_full_d = (occ >= AF_TH);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wcount_q       <= '0;
      walmost_full_q <= 1'b0;
    end else begin
      wcount_q       <= wcount_d;
      walmost_full_q <= walmost_full_d;
    end
  end

  assign wif.wcount       = wcount_q;
  assign wif.walmost_full = walmost_full_q;
`else
  assign wif.wcount       = '0;
  assign wif.walmost_full = 1'b0;
`endif
endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full (ADDR_WIDTH=4, AF_MARGIN=2) with a per-edge scoreboard.
module tb_wptr_full;
  logic wclk;
  logic wrst;

  wptr_full_if #(.ADDR_WIDTH(4)) wif ();

  wptr_full #(.ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .wif  (wif)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic [4:0] wcount;
    logic       waf;
    logic       wovf;
  } exp_t;

  exp_t sbq[$];
  int   nassert = 0;
  int   nfail   = 0;

  // reference state
  logic [4:0] m_bin;
  logic [4:0] m_gray;
  logic       m_full, m_ovf, m_af;
  logic [4:0] m_cnt;
  logic [4:0] ghist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bin = '0; m_gray = '0; m_full = 0; m_ovf = 0; m_af = 0; m_cnt = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_waddr"}, 32'(wif.waddr), 0);
    chk({tag, "_wptr"},  32'(wif.wptr), 0);
    chk({tag, "_wfull"}, 32'(wif.wfull), 0);
    chk({tag, "_wcount"}, 32'(wif.wcount), 0);
    chk({tag, "_waf"},   32'(wif.walmost_full), 0);
    chk({tag, "_wovf"},  32'(wif.woverflow), 0);
  endtask

  // One wclk cycle: drive, check wen, predict, clock, compare prediction.
  task automatic cycle(input logic inc, input logic [4:0] rq, input logic clr);
    exp_t e;
    logic acc;
    logic [4:0] nb, rb, occ;
    wif.winc = inc; wif.wq2_rptr = rq; wif.wovf_clr = clr;
    #1;
    acc = inc && !m_full;
    chk("wen", 32'(wif.wen), 32'(acc));
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    nb = m_bin + 5'(acc);
    m_gray = nb ^ (nb >> 1);
    m_full = (m_gray == {~rq[4:3], rq[2:0]});
    rb = '0;
    for (int i = 0; i < 5; i++) rb[i] = ^(rq >> i);
    occ = nb - rb;
`ifdef WPTR_FULL_ALMOST_FULL_EN
    m_cnt = occ;
    m_af  = (occ >= 5'd14);
`else
    m_cnt = '0;
    m_af  = 1'b0;
`endif
    m_bin = nb;
    e.waddr = nb[3:0]; e.wptr = m_gray; e.wfull = m_full;
    e.wcount = m_cnt; e.waf = m_af; e.wovf = m_ovf;
    sbq.push_back(e);
    @(posedge wclk); #1;
    e = sbq.pop_front();
    chk("sb_waddr",  32'(wif.waddr),  32'(e.waddr));
    chk("sb_wptr",   32'(wif.wptr),   32'(e.wptr));
    chk("sb_wfull",  32'(wif.wfull),  32'(e.wfull));
    chk("sb_wcount", 32'(wif.wcount), 32'(e.wcount));
    chk("sb_waf",    32'(wif.walmost_full), 32'(e.waf));
    chk("sb_wovf",   32'(wif.woverflow), 32'(e.wovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] prev, rq;
    wrst = 1'b1;
    wif.winc = 1'b1; wif.wq2_rptr = '0; wif.wovf_clr = 1'b0;
    model_reset();
    #2;
    chk_all_zero("reset");
    @(posedge wclk); #1;
    wrst = 1'b0;

    // Fill to full
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, 5'd0, 1'b0);
      chk("fill_waddr", 32'(wif.waddr), 32'(k % 16));
`ifdef WPTR_FULL_ALMOST_FULL_EN
      if (k == 13) chk("fill_af13", 32'(wif.walmost_full), 0);
      if (k == 14) chk("fill_af14", 32'(wif.walmost_full), 1);
`endif
      if (k == 15) chk("fill_nfull15", 32'(wif.wfull), 0);
    end
    chk("full_wptr",  32'(wif.wptr), 32'h18);
    chk("full_wfull", 32'(wif.wfull), 1);
`ifdef WPTR_FULL_ALMOST_FULL_EN
    chk("full_wcount", 32'(wif.wcount), 16);
`endif

    // Overflow
    cycle(1'b1, 5'd0, 1'b0);
    chk("ovf_wptr", 32'(wif.wptr), 32'h18);
    chk("ovf_set",  32'(wif.woverflow), 1);
    cycle(1'b1, 5'd0, 1'b1);
    chk("ovf_setprio", 32'(wif.woverflow), 1);
    cycle(1'b0, 5'd0, 1'b1);
    chk("ovf_clr", 32'(wif.woverflow), 0);

    // Full release then refill
    cycle(1'b0, 5'b00001, 1'b0);
    chk("rel_wfull", 32'(wif.wfull), 0);
`ifdef WPTR_FULL_ALMOST_FULL_EN
    chk("rel_wcount", 32'(wif.wcount), 15);
`endif
    cycle(1'b1, 5'b00001, 1'b0);
    chk("refill_wfull", 32'(wif.wfull), 1);

    // Reset again before the wrap run
    #2; wrst = 1'b1; wif.wq2_rptr = '0; #1;
    chk_all_zero("reset2");
    model_reset();
    @(posedge wclk); #1;
    wrst = 1'b0;

    // Wrap with read pointer trailing 3 cycles
    ghist.delete();
    ghist.push_back(5'd0);
    for (int k = 1; k <= 47; k++) begin
      rq = (ghist.size() >= 3) ? ghist[ghist.size()-3] : 5'd0;
      prev = wif.wptr;
      cycle(1'b1, rq, 1'b0);
      ghist.push_back(m_gray);
      chk("wrap_onebit", 32'($countones(wif.wptr ^ prev)), 1);
      chk("wrap_nfull", 32'(wif.wfull), 0);
      if (k == 15) chk("wrap_msb15", 32'(wif.wptr[4]), 0);
      if (k == 16) chk("wrap_msb16", 32'(wif.wptr[4]), 1);
      if (k == 31) chk("wrap_msb31", 32'(wif.wptr[4]), 1);
      if (k == 32) chk("wrap_msb32", 32'(wif.wptr[4]), 0);
      if (k == 40) chk("wrap_waddr40", 32'(wif.waddr), 8);
    end

    // Mid-burst reset (7 writes past the wrap run), with winc held high
    #2; wrst = 1'b1; wif.winc = 1'b1; wif.wq2_rptr = '0; #1;
    chk_all_zero("midrst");
    model_reset();
    @(posedge wclk); #1;
    chk_all_zero("midrst_hold");
    wrst = 1'b0; #1;
    chk("resume_waddr", 32'(wif.waddr), 0);
    for (int k = 1; k <= 4; k++) cycle(1'b1, 5'd0, 1'b0);
    chk("resume_waddr4", 32'(wif.waddr), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/wptr_full.md
# wptr_full

Write-domain pointer and full-flag generator for the asynchronous FIFO. It owns the binary write counter and produces the RAM write address and the Gray-coded write pointer (`wptr`) that the write-to-read synchroniser carries across. It compares that pointer against the read pointer already synchronised into `wclk` (`wq2_rptr`) to produce a registered, conservative `wfull`, plus occupancy, almost-full and overflow status.

## Interface
- `ADDR_WIDTH`, 4 — address bits; FIFO depth = 2^ADDR_WIDTH; must be ≥ 2.
- `AF_MARGIN`, 2 — `walmost_full` asserts when occupancy ≥ depth − AF_MARGIN; range 1..depth−1.

Ports:
- `wclk` in 1 — write clock; sole clock.
- `wrst` in 1 — **asynchronous, active-high reset.**
- `winc` in 1 — write request from producer.
- `wq2_rptr` in ADDR_WIDTH+1 — Gray read pointer, already 2-flop synchronised into `wclk`.
- `wovf_clr` in 1 — clears the sticky overflow flag.
- `waddr` out ADDR_WIDTH — RAM write address (binary).
- `wptr` out ADDR_WIDTH+1 — Gray write pointer, with an extra MSB for wrap.
- `wen` out 1 — RAM write enable; combinational `winc & ~wfull`.
- `wfull` out 1 — FIFO full, registered.
- `wcount` out ADDR_WIDTH+1 — occupancy as seen from the write side, registered.
- `walmost_full` out 1 — almost-full, registered.
- `woverflow` out 1 — sticky: a write was attempted while full.

## Operation
- **Registered state:** binary counter `wbin[ADDR_WIDTH:0]`, plus `wptr`, `wfull`, `wcount`, `walmost_full` and `woverflow`.
- **Write acceptance:** a write is accepted when `winc && !wfull`.
  - `wbinnext = wbin + accepted`, wrapping modulo 2^(ADDR_WIDTH+1).
  - `wgraynext = wbinnext ^ (wbinnext >> 1)`.
  - `waddr = wbin[ADDR_WIDTH-1:0]`, so the slot written is the pre-increment address.
- **Full detection:**
  - `wfull <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]})`, where A = ADDR_WIDTH.
  - `wptr <= wgraynext`.
  - `wptr` changes by exactly one bit per accepted write and is only ever driven from a register (CDC requirement).
- **Occupancy:**
  - `rbin_s = gray2bin(wq2_rptr)`.
  - `wcount <= wbinnext − rbin_s`, computed modulo 2^(ADDR_WIDTH+1); result range 0..2^A.
  - `walmost_full <= (wbinnext − rbin_s) ≥ 2^A − AF_MARGIN`.
- **Overflow:**
  - `woverflow` sets on `winc && wfull`; set takes priority.
  - Otherwise it clears on `wovf_clr`.
  - A write rejected while full changes nothing else.
- **Full/empty bias:** `wfull` and `wcount` are pessimistic, because the read pointer is stale by the 2-cycle sync delay. `wfull` may stay high after reads, but never falsely reports space.
- **Simultaneous events:**
  - A write accepted in the same cycle `wq2_rptr` advances: both are reflected in the next `wfull` and `wcount`.
  - A write that fills the FIFO sets `wfull` on the same edge it is accepted.
- **Reset:**
  - Asserting `wrst` at any time, mid-burst included, immediately forces every output register to zero: `wbin`, `wptr`, `waddr`, `wfull`, `wcount`, `walmost_full` and `woverflow`.
  - The read domain must be reset in the same window.

## Timing
- **Reset values:** all registered outputs are 0. `wen` follows `winc` once reset is released, since `wfull` = 0.
- **Write latency:** an accepted write at edge N updates `waddr` and `wptr` at N; `wfull`, `wcount` and `walmost_full` are valid after N.
- **Full release:** `wq2_rptr` changing at edge N clears `wfull` at edge N+1. That is roughly 3 `wclk` after the read-side `rptr` edge.
- **Pipelining:** back-to-back writes are accepted every cycle up to full; there are no bubbles.

## Configuration
- Macro `WPTR_FULL_ALMOST_FULL_EN`.
- **Defined:** the `gray2bin` converter, subtractor, `wcount` and `walmost_full` registers are built as described above.
- **Undefined:** that logic is omitted. `wcount` and `walmost_full` are tied to 0; `wfull`, `wptr`, `waddr`, `wen` and `woverflow` are unaffected.

## Test plan
All scenarios use ADDR_WIDTH = 4 and AF_MARGIN = 2.
- **Reset:** pulse `wrst` with `winc`=1 → `waddr`=0, `wptr`=5'b00000, `wfull`=0, `wcount`=0, `woverflow`=0, with no `wclk` edge needed.
- **Fill to full:** `wq2_rptr`=0, 16 consecutive `winc` → `waddr` steps 0..15 then 0; `wptr`=5'b11000 (gray 16) and `wfull`=1 on the 16th edge; `wcount`=16; `walmost_full`=1 from the 14th edge.
- **Overflow:** 17th `winc` while full → `wen`=0, `wptr` unchanged, `woverflow`=1. Assert `wovf_clr` together with `winc` → `woverflow` stays 1. `wovf_clr` alone → `woverflow`=0.
- **Full release:** while full, drive `wq2_rptr`=5'b00001 → `wfull`=0 and `wcount`=15 one edge later; one write → `wfull`=1 again.
- **Wrap:** 40 writes with `wq2_rptr` following `wptr` 3 cycles behind → `waddr` wraps 15→0 twice; `wptr` MSB toggles at writes 16 and 32; every `wptr` change flips exactly 1 bit; `wfull` never asserts.
- **Mid-burst reset, macro off:** assert `wrst` after 7 writes → all outputs 0 asynchronously and writing resumes at `waddr`=0. With `WPTR_FULL_ALMOST_FULL_EN` undefined, `wcount`=0 and `walmost_full`=0 throughout.
